// File: rtl/neuron_requant_if.sv
// Sum/bias intake and activation output bundle for the requantisation stage.
// The master side produces sums and consumes activations.
interface neuron_requant_if #(
    parameter int BITS = 8
);
    logic                   sum_valid;
    logic                   sum_ready;
    logic signed [BITS+24:0] sum_in;
    logic signed [BITS+16:0] bias_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS-1:0]        out_data;
    logic [7:0]             out_index;
    logic                   out_last;
    logic                   sat_flag;

    modport master (
        output sum_valid, sum_in, bias_in, out_ready,
        input  sum_ready, out_valid, out_data, out_index, out_last, sat_flag
    );

    modport slave (
        input  sum_valid, sum_in, bias_in, out_ready,
        output sum_ready, out_valid, out_data, out_index, out_last, sat_flag
    );
endinterface

// File: rtl/neuron_requant.sv
// Adds bias to an accumulated dot product, rescales with round-half-up,
// applies ReLU and unsigned saturation, and hands out one activation per neuron.
module neuron_requant #(
    parameter int BITS    = 8,
    parameter int SHIFT   = 8,
    parameter int NEURONS = 10
) (
    input  logic             clk,
    input  logic             rstn,
    neuron_requant_if.slave  bus
);
    localparam int AW = BITS + 26;
    localparam int RW = BITS + 27;
    // Shifting a one up and back down yields 2^(SHIFT-1), or zero when SHIFT is 0.
    localparam logic signed [RW-1:0] RND      = (RW'(1) << SHIFT) >> 1;
    localparam logic [BITS-1:0]      MAX_ACT  = '1;
    localparam logic [7:0]           LAST_IDX = 8'(NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_q;
    logic signed [AW-1:0]   acc_q;
    logic [BITS-1:0]        out_data_q;
    logic [7:0]             out_index_q;
    logic                   sat_q;

    logic signed [AW-1:0]   acc_d;
    logic [BITS:0]          res_d;
    logic [7:0]             out_index_d;
    logic                   sum_ready_s;
    logic                   out_valid_s;

    // Returns {clipped_high, activation}; the extra headroom bit keeps the rounding add exact.
    function automatic logic [BITS:0] requant(input logic signed [AW-1:0] acc);
        logic signed [RW-1:0] r;
        r = ($signed({acc[AW-1], acc}) + RND) >>> SHIFT;
        if (r[RW-1]) begin
            return {1'b0, {BITS{1'b0}}};
        end else if (|r[RW-2:BITS]) begin
            return {1'b1, MAX_ACT};
        end else begin
            return {1'b0, r[BITS-1:0]};
        end
    endfunction

    assign acc_d       = AW'(bus.sum_in) + AW'(bus.bias_in);
    assign res_d       = requant(acc_q);
    assign out_index_d = (out_index_q == LAST_IDX) ? 8'd0 : out_index_q + 8'd1;

    // Handshake flags are masked by rstn so both read low while reset is held.
    assign sum_ready_s = rstn && (state_q == IDLE);
    assign out_valid_s = rstn && (state_q == HOLD);

    assign bus.sum_ready = sum_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_valid_s && (out_index_q == LAST_IDX);
    assign bus.sat_flag  = sat_q;

    // Control FSM with the datapath registers it owns.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= 8'd0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.sum_valid) begin
                        acc_q   <= acc_d;
                        state_q <= SCALE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCALE: begin
                    out_data_q <= res_d[BITS-1:0];
                    if (res_d[BITS]) begin
                        sat_q <= 1'b1;
                    end else begin
                        sat_q <= sat_q;
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_index_q <= out_index_d;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_requant.sv
// Directed and randomised checks of neuron_requant against an integer reference model.
module tb_neuron_requant;
    localparam int BITS    = 8;
    localparam int SHIFT   = 8;
    localparam int NEURONS = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    neuron_requant_if #(.BITS(BITS)) bus ();

    neuron_requant #(.BITS(BITS), .SHIFT(SHIFT), .NEURONS(NEURONS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   total  = 0;
    int   passed = 0;
    int   m_idx  = 0;
    logic m_sat  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias add, floor((acc + 2^(SHIFT-1)) / 2^SHIFT), then ReLU and clip.
    function automatic logic [BITS:0] model(input longint s, input longint b);
        longint x, q, div, maxv;
        div  = longint'(1) << SHIFT;
        maxv = (longint'(1) << BITS) - 1;
        x = s + b + ((SHIFT == 0) ? 0 : div / 2);
        q = (x >= 0) ? x / div : -((-x + div - 1) / div);
        if (q < 0) return '0;
        else if (q > maxv) return {1'b1, BITS'(maxv)};
        else return {1'b0, BITS'(q)};
    endfunction

    function automatic longint rand_sum();
        logic signed [32:0] w;
        case ($urandom_range(0, 2))
            0: begin
                w = 33'({$urandom, $urandom});
                return longint'(w);
            end
            1: return longint'($urandom_range(0, 70000)) - 3000;
            default: return longint'($urandom_range(0, 600)) - 300;
        endcase
    endfunction

    function automatic longint rand_bias();
        logic signed [24:0] w;
        if ($urandom_range(0, 3) == 0) begin
            w = 25'($urandom);
            return longint'(w);
        end else begin
            return longint'($urandom_range(0, 2000)) - 1000;
        end
    endfunction

    // One full result: offer, check latency, optional backpressure with ignored pulses, release.
    task automatic transact(input longint s, input longint b, input int hold, input bit pulse);
        logic [BITS:0] exp;
        int waited = 0;
        while (bus.sum_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("sum_ready_before_send", bus.sum_ready, 1);
        exp = model(s, b);
        bus.sum_in    = 33'(s);
        bus.bias_in   = 25'(b);
        bus.sum_valid = 1'b1;
        tick();
        bus.sum_valid = 1'b0;
        chk("scale_out_valid", bus.out_valid, 0);
        chk("scale_sum_ready", bus.sum_ready, 0);
        chk("scale_out_last", bus.out_last, 0);
        tick();
        if (exp[BITS]) m_sat = 1'b1;
        chk("hold_out_valid", bus.out_valid, 1);
        chk("out_data", bus.out_data, exp[BITS-1:0]);
        chk("out_index", bus.out_index, m_idx);
        chk("out_last", bus.out_last, (m_idx == NEURONS - 1));
        chk("sat_flag", bus.sat_flag, m_sat);
        for (int i = 0; i < hold; i++) begin
            bus.sum_valid = pulse & ((i % 2) == 0);
            bus.sum_in    = 33'(rand_sum());
            tick();
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", bus.out_data, exp[BITS-1:0]);
            chk("bp_out_index", bus.out_index, m_idx);
            chk("bp_sum_ready", bus.sum_ready, 0);
        end
        bus.sum_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        m_idx = (m_idx + 1) % NEURONS;
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_sum_ready", bus.sum_ready, 1);
        chk("idle_out_index", bus.out_index, m_idx);
        chk("idle_sat_flag", bus.sat_flag, m_sat);
    endtask

    initial begin
        logic [BITS:0] exp;
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
        bus.bias_in   = '0;
        bus.out_ready = 1'b0;

        // Power-on reset
        tick();
        tick();
        chk("rst_sum_ready", bus.sum_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        rstn = 1'b1;
        #1;
        chk("post_rst_sum_ready", bus.sum_ready, 1);

        // Directed values: nominal, rounding boundary, ReLU, saturation, sticky flag
        transact(1000, 0, 0, 1'b0);
        transact(384, 0, 0, 1'b0);
        transact(383, 0, 0, 1'b0);
        transact(-5000, 100, 0, 1'b0);
        chk("relu_no_sat", bus.sat_flag, 0);
        transact(100000, 0, 0, 1'b0);
        chk("sat_set", bus.sat_flag, 1);
        transact(1000, 0, 0, 1'b0);
        chk("sat_sticky", bus.sat_flag, 1);

        // Backpressure with ignored sum_valid pulses
        transact(rand_sum(), rand_bias(), 5, 1'b1);

        // Random traffic across several index wraps
        for (int n = 0; n < 20; n++) begin
            transact(rand_sum(), rand_bias(), int'($urandom_range(0, 2)), 1'b1);
        end

        // Reset while holding the result for index 3
        while (m_idx != 3) transact(rand_sum(), rand_bias(), 0, 1'b0);
        exp = model(100000, 0);
        bus.sum_in    = 33'(100000);
        bus.bias_in   = '0;
        bus.sum_valid = 1'b1;
        tick();
        bus.sum_valid = 1'b0;
        tick();
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_index", bus.out_index, 3);
        chk("pre_rst_data", bus.out_data, exp[BITS-1:0]);
        rstn = 1'b0;
        tick();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_sum_ready", bus.sum_ready, 0);
        chk("mid_rst_out_index", bus.out_index, 0);
        chk("mid_rst_sat_flag", bus.sat_flag, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        rstn  = 1'b1;
        m_idx = 0;
        m_sat = 1'b0;
        #1;
        chk("rel_sum_ready", bus.sum_ready, 1);
        tick();
        chk("discard_out_valid", bus.out_valid, 0);
        chk("discard_sum_ready", bus.sum_ready, 1);
        transact(1000, 0, 0, 1'b0);
        transact(rand_sum(), rand_bias(), 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
